// File: rtl/filter_iir_bank.sv
// Time-multiplexed bank of first-order IIR low-pass filters sharing one
// datapath; per-channel state and shift constant, sequenced clear.
module filter_iir_bank #(
    parameter int N        = 16,
    parameter int NI       = 20,
    parameter int CHANNELS = 4,
    parameter int IIRCONST = 6,
    parameter int CW       = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [N-1:0] in,
    input  logic [CW-1:0]       in_ch,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [N-1:0] out,
    output logic [CW-1:0]       out_ch,
    output logic                out_valid,
    input  logic                cfg_write,
    input  logic [CW-1:0]       cfg_ch,
    input  logic [4:0]          cfg_k,
    input  logic                clear
);

    localparam int F = NI - N;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cc_q, cc_d;
    logic                rdy_q;
    logic                clr_wr;
    logic                accept;

    logic                st_vld_q;
    logic signed [N-1:0] st_in_q;
    logic [CW-1:0]       st_ch_q;
    logic [4:0]          st_k_q;

    logic signed [NI-1:0] s_q [CHANNELS];
    logic [4:0]           k_q [CHANNELS];

    logic signed [N-1:0] out_q;
    logic [CW-1:0]       out_ch_q;
    logic                out_valid_q;

    logic signed [NI-1:0] s_cur;
    logic signed [NI-1:0] s_new;
    logic signed [NI:0]   s_ext;
    logic signed [NI:0]   x_w;
    logic signed [NI:0]   d_w;
    logic signed [NI:0]   a_w;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cc_q    <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cc_d    = cc_q;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    cc_d    = '0;
                end
            end
            CLEAR: begin
                cc_d = cc_q + CW'(1);
                if (cc_q == CW'(CHANNELS - 1)) begin
                    state_d = IDLE;
                    cc_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        clr_wr   = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = rdy_q;
            CLEAR:   clr_wr = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // d is one bit wider than the state so x - s never wraps
    assign s_cur = s_q[st_ch_q];
    assign s_ext = {s_cur[NI-1], s_cur};
    assign x_w   = $signed({{(NI + 1 - N){st_in_q[N-1]}}, st_in_q}) <<< F;
    assign d_w   = x_w - s_ext;
    assign a_w   = d_w >>> st_k_q;
    assign s_new = NI'(s_ext + a_w);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_vld_q    <= 1'b0;
            st_in_q     <= '0;
            st_ch_q     <= '0;
            st_k_q      <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            st_vld_q    <= accept;
            out_valid_q <= st_vld_q;
            if (accept) begin
                st_in_q <= in;
                st_ch_q <= in_ch;
                st_k_q  <= k_q[in_ch];
            end
            if (st_vld_q) begin
                out_q    <= N'(s_new >>> F);
                out_ch_q <= st_ch_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                k_q[c] <= 5'(IIRCONST);
            end
        end else if (cfg_write) begin
            k_q[cfg_ch] <= cfg_k;
        end
    end

    // a clear write beats a filter write to the same channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                s_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (clr_wr && cc_q == CW'(c)) begin
                    s_q[c] <= '0;
                end else if (st_vld_q && st_ch_q == CW'(c)) begin
                    s_q[c] <= s_new;
                end
            end
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_filter_iir_bank.sv
// Directed bench for filter_iir_bank: hand-computed outputs for k=0,
// k=1 ramps, extremes, interleaving, clear and async reset.
module tb_filter_iir_bank;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] in_s = '0;
    logic [1:0]         in_ch = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] out_s;
    logic [1:0]         out_ch;
    logic               out_valid;
    logic               cfg_write = 1'b0;
    logic [1:0]         cfg_ch = '0;
    logic [4:0]         cfg_k = '0;
    logic               clear = 1'b0;

    int checks = 0;
    int errors = 0;

    filter_iir_bank #(
        .N(16), .NI(20), .CHANNELS(4), .IIRCONST(6)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in(in_s), .in_ch(in_ch), .in_valid(in_valid), .in_ready(in_ready),
        .out(out_s), .out_ch(out_ch), .out_valid(out_valid),
        .cfg_write(cfg_write), .cfg_ch(cfg_ch), .cfg_k(cfg_k),
        .clear(clear)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [4:0] k);
        cfg_write = 1'b1;
        cfg_ch    = ch;
        cfg_k     = k;
        step();
        cfg_write = 1'b0;
    endtask

    task automatic drive(input logic [1:0] ch, input int v);
        in_valid = 1'b1;
        in_ch    = ch;
        in_s     = 16'(v);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_s !== 16'sd0 || out_ch !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got out=%0d ch=%0d v=%b want 0 0 0",
                     out_s, out_ch, out_valid);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_k0();
        cfg(2'd2, 5'd0);
        drive(2'd2, 1000);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL k0_early got v=%b want 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_s !== 16'sd1000 || out_ch !== 2'd2) begin
            errors++;
            $display("FAIL k0_out got v=%b out=%0d ch=%0d want 1 1000 2",
                     out_valid, out_s, out_ch);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_s !== 16'sd1000) begin
            errors++;
            $display("FAIL k0_hold got v=%b out=%0d want 0 1000",
                     out_valid, out_s);
        end
    endtask

    task automatic test_back_to_back();
        int exp_v [3] = '{500, 750, 875};
        cfg(2'd0, 5'd1);
        drive(2'd0, 1000);
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) in_valid = 1'b0;
            step();
            checks++;
            if (out_valid !== 1'b1 || out_s !== 16'(exp_v[i]) || out_ch !== 2'd0) begin
                errors++;
                $display("FAIL b2b_%0d got v=%b out=%0d want 1 %0d",
                         i, out_valid, out_s, exp_v[i]);
            end
        end
    endtask

    task automatic test_extremes();
        cfg(2'd1, 5'd0);
        drive(2'd1, -32768);
        step();
        drive(2'd1, 32767);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_s !== -16'sd32768) begin
            errors++;
            $display("FAIL ext_min got v=%b out=%0d want 1 -32768",
                     out_valid, out_s);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_s !== 16'sd32767) begin
            errors++;
            $display("FAIL ext_max got v=%b out=%0d want 1 32767",
                     out_valid, out_s);
        end
    endtask

    task automatic test_interleave();
        logic [1:0] chs [4] = '{2'd3, 2'd0, 2'd3, 2'd0};
        int vin  [4] = '{100, -1000, 100, -1000};
        int vexp [4] = '{24, -63, 43, -532};
        cfg(2'd3, 5'd2);
        drive(2'd3, -1);
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_s !== -16'sd1 || out_ch !== 2'd3) begin
            errors++;
            $display("FAIL neg_floor got v=%b out=%0d ch=%0d want 1 -1 3",
                     out_valid, out_s, out_ch);
        end
        drive(chs[0], vin[0]);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(chs[i+1], vin[i+1]);
            else in_valid = 1'b0;
            step();
            checks++;
            if (out_valid !== 1'b1 || out_s !== 16'(vexp[i]) || out_ch !== chs[i]) begin
                errors++;
                $display("FAIL ilv_%0d got v=%b out=%0d ch=%0d want 1 %0d %0d",
                         i, out_valid, out_s, out_ch, vexp[i], chs[i]);
            end
        end
    endtask

    task automatic test_clear();
        cfg(2'd1, 5'd6);
        clear = 1'b1;
        step();
        clear = 1'b0;
        drive(2'd0, 5000);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL clr_busy_%0d got rdy=%b v=%b want 0 0",
                         i, in_ready, out_valid);
            end
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_done got rdy=%b want 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_noacc got v=%b want 0", out_valid);
        end
        drive(2'd0, 1000);
        step();
        drive(2'd1, 6400);
        step();
        drive(2'd3, 100);
        checks++;
        if (out_valid !== 1'b1 || out_s !== 16'sd500 || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL clr_ch0 got v=%b out=%0d want 1 500",
                     out_valid, out_s);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_s !== 16'sd100 || out_ch !== 2'd1) begin
            errors++;
            $display("FAIL clr_ch1 got v=%b out=%0d want 1 100",
                     out_valid, out_s);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_s !== 16'sd25 || out_ch !== 2'd3) begin
            errors++;
            $display("FAIL clr_ch3_kept got v=%b out=%0d want 1 25",
                     out_valid, out_s);
        end
    endtask

    task automatic test_reset_mid();
        clear = 1'b1;
        drive(2'd2, 1000);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_s !== 16'sd0 || out_ch !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_out got out=%0d ch=%0d v=%b want 0 0 0",
                     out_s, out_ch, out_valid);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_after got v=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
        drive(2'd2, 6400);
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_s !== 16'sd100 || out_ch !== 2'd2) begin
            errors++;
            $display("FAIL rstmid_ch2 got v=%b out=%0d want 1 100",
                     out_valid, out_s);
        end
    endtask

    initial begin
        test_reset();
        test_k0();
        test_back_to_back();
        test_extremes();
        test_interleave();
        test_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
